btb_predictor: RTL and testbench

- Set-associative branch target buffer with per-entry saturating direction counters and LRU replacement.
- Serves one registered fetch-stage lookup per cycle.
- Accepts LANES resolved-branch updates per cycle from the superscalar execute stage.
- Provides a multi-cycle flush walker for context switches and self-modifying code.

---
 rtl/btb_predictor.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_btb_predictor.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: set-associative branch target buffer with direction
// counters, exact LRU, multi-lane execute updates and a flush walker.
// Ports:
//   clk, reset_n (sync, active-low), enable, stall
//   lookup_pc -> pred_hit / pred_taken / pred_target (1-cycle registered)
//   upd_valid / upd_pc / upd_target / upd_taken : LANES execute updates
//   flush_req / flush_busy : invalidation walk, one set per cycle
//   hit_count / lookup_count : saturating statistics
module btb_predictor #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int LANES = 2,
  parameter int CTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  stall,
  input  logic [63:0]           lookup_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [63:0]           pred_target,
  input  logic [LANES-1:0]      upd_valid,
  input  logic [LANES*64-1:0]   upd_pc,
  input  logic [LANES*64-1:0]   upd_target,
  input  logic [LANES-1:0]      upd_taken,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic [31:0]           hit_count,
  output logic [31:0]           lookup_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PAIRS = WAYS * (WAYS - 1) / 2;
  localparam int LRU_W = (PAIRS > 0) ? PAIRS : 1;
  localparam int LP_W  = (LRU_W > 1) ? $clog2(LRU_W) : 1;

  localparam logic [CTR_W-1:0] CTR_T   = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } state_t;

  // LRU is an upper-triangular recency matrix: bit (i,j), i<j, set
  // means way i is newer than way j. All-zero is a legal order
  // (higher index newer), so clearing it on reset/flush is safe.
  function automatic int pidx(input int i, input int j);
    return i * WAYS - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic logic newer(
    input logic [LRU_W-1:0] m,
    input int               i,
    input int               j
  );
    if (i < j) return m[LP_W'(pidx(i, j))];
    return ~m[LP_W'(pidx(j, i))];
  endfunction

  function automatic logic [LRU_W-1:0] touch(
    input logic [LRU_W-1:0] m,
    input int               w
  );
    logic [LRU_W-1:0] r;
    r = m;
    for (int j = 0; j < WAYS; j++) begin
      if (j > w)      r[LP_W'(pidx(w, j))] = 1'b1;
      else if (j < w) r[LP_W'(pidx(j, w))] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] victim(
    input logic [LRU_W-1:0] m
  );
    logic [WAY_W-1:0] v;
    logic             found;
    logic             old;
    v     = '0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      old = 1'b1;
      for (int j = 0; j < WAYS; j++)
        if (j != i && !newer(m, j, i)) old = 1'b0;
      if (old && !found) begin
        v     = WAY_W'(i);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  logic [WAYS-1:0]  r_valid [SETS];
  logic [63:0]      r_tag   [SETS][WAYS];
  logic [63:0]      r_tgt   [SETS][WAYS];
  logic [CTR_W-1:0] r_ctr   [SETS][WAYS];
  logic [LRU_W-1:0] r_lru   [SETS];

  logic [WAYS-1:0]  w_valid [SETS];
  logic [63:0]      w_tag   [SETS][WAYS];
  logic [63:0]      w_tgt   [SETS][WAYS];
  logic [CTR_W-1:0] w_ctr   [SETS][WAYS];
  logic [LRU_W-1:0] w_lru   [SETS];

  state_t           r_state;
  state_t           w_state_nx;
  logic [IDX_W-1:0] r_walk;
  logic [IDX_W-1:0] w_walk_nx;

  logic             r_pred_hit;
  logic             r_pred_tk;
  logic [63:0]      r_pred_tgt;
  logic [31:0]      r_hit_cnt;
  logic [31:0]      r_lk_cnt;

  logic             w_busy;
  logic             w_accept;
  logic [IDX_W-1:0] w_lk_set;
  logic             w_lk_hit;
  logic [WAY_W-1:0] w_lk_way;
  logic             w_lk_tk;
  logic [63:0]      w_lk_tgt;

  assign w_busy   = (r_state == S_WALK);
  assign w_accept = enable && !stall && !w_busy;
  assign w_lk_set = lookup_pc[IDX_W+1:2];

  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_lk_hit
          && r_valid[w_lk_set][WAY_W'(w)]
          && r_tag[w_lk_set][WAY_W'(w)] == lookup_pc) begin
        w_lk_hit = 1'b1;
        w_lk_way = WAY_W'(w);
      end
    end
    w_lk_tk  = w_lk_hit
            && (r_ctr[w_lk_set][w_lk_way] >= CTR_T);
    w_lk_tgt = w_lk_hit ? r_tgt[w_lk_set][w_lk_way] : '0;
  end

  // Lanes are folded in order against the running next-state so a
  // later lane observes what an earlier lane wrote this cycle.
  always_comb begin
    logic [IDX_W-1:0] s;
    logic [63:0]      pc;
    logic [63:0]      tg;
    logic             hit;
    logic             free;
    logic [WAY_W-1:0] hw;
    logic [WAY_W-1:0] fw;
    w_valid = r_valid;
    w_tag   = r_tag;
    w_tgt   = r_tgt;
    w_ctr   = r_ctr;
    w_lru   = r_lru;
    s    = '0;
    pc   = '0;
    tg   = '0;
    hit  = 1'b0;
    free = 1'b0;
    hw   = '0;
    fw   = '0;
    if (w_accept && w_lk_hit)
      w_lru[w_lk_set] = touch(w_lru[w_lk_set], int'(w_lk_way));
    for (int l = 0; l < LANES; l++) begin
      pc   = upd_pc[l*64 +: 64];
      tg   = upd_target[l*64 +: 64];
      s    = pc[IDX_W+1:2];
      hit  = 1'b0;
      hw   = '0;
      free = 1'b0;
      fw   = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (!hit
            && w_valid[s][WAY_W'(w)]
            && w_tag[s][WAY_W'(w)] == pc) begin
          hit = 1'b1;
          hw  = WAY_W'(w);
        end
        if (!free && !w_valid[s][WAY_W'(w)]) begin
          free = 1'b1;
          fw   = WAY_W'(w);
        end
      end
      if (w_accept && upd_valid[l]) begin
        if (upd_taken[l]) begin
          if (hit) begin
            if (w_tgt[s][hw] == tg) begin
              if (w_ctr[s][hw] != CTR_MAX)
                w_ctr[s][hw] = w_ctr[s][hw] + CTR_W'(1);
            end else begin
              w_tgt[s][hw] = tg;
              w_ctr[s][hw] = CTR_T;
            end
            w_lru[s] = touch(w_lru[s], int'(hw));
          end else begin
            if (!free) fw = victim(w_lru[s]);
            w_valid[s][fw] = 1'b1;
            w_tag[s][fw]   = pc;
            w_tgt[s][fw]   = tg;
            w_ctr[s][fw]   = CTR_T;
            w_lru[s]       = touch(w_lru[s], int'(fw));
          end
        end else if (hit) begin
          if (w_ctr[s][hw] != '0)
            w_ctr[s][hw] = w_ctr[s][hw] - CTR_W'(1);
          if (w_ctr[s][hw] == '0)
            w_valid[s][hw] = 1'b0;
        end
      end
    end
    if (w_busy) begin
      w_valid[r_walk] = '0;
      w_lru[r_walk]   = '0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_walk_nx  = r_walk;
    unique case (r_state)
      S_IDLE: begin
        if (flush_req) begin
          w_state_nx = S_WALK;
          w_walk_nx  = '0;
        end
      end
      S_WALK: begin
        w_walk_nx = r_walk + IDX_W'(1);
        if (r_walk == IDX_W'(SETS - 1))
          w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid    <= '{default: '0};
      r_ctr      <= '{default: '0};
      r_lru      <= '{default: '0};
      r_state    <= S_IDLE;
      r_walk     <= '0;
      r_pred_hit <= 1'b0;
      r_pred_tk  <= 1'b0;
      r_pred_tgt <= '0;
      r_hit_cnt  <= '0;
      r_lk_cnt   <= '0;
    end else if (enable) begin
      r_valid <= w_valid;
      r_ctr   <= w_ctr;
      r_lru   <= w_lru;
      r_state <= w_state_nx;
      r_walk  <= w_walk_nx;
      if (w_busy) begin
        r_pred_hit <= 1'b0;
        r_pred_tk  <= 1'b0;
        r_pred_tgt <= '0;
      end else if (!stall) begin
        r_pred_hit <= w_lk_hit;
        r_pred_tk  <= w_lk_tk;
        r_pred_tgt <= w_lk_tgt;
        if (r_lk_cnt != '1)
          r_lk_cnt <= r_lk_cnt + 32'd1;
        if (w_lk_hit && r_hit_cnt != '1)
          r_hit_cnt <= r_hit_cnt + 32'd1;
      end
    end
  end

  // Tag/target payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (enable) begin
      r_tag <= w_tag;
      r_tgt <= w_tgt;
    end
  end

  // The pred register can still hold the lookup taken on the flush
  // cycle, so hide it for the whole walk.
  assign pred_hit     = r_pred_hit && !w_busy;
  assign pred_taken   = r_pred_tk && !w_busy;
  assign pred_target  = w_busy ? '0 : r_pred_tgt;
  assign flush_busy   = w_busy;
  assign hit_count    = r_hit_cnt;
  assign lookup_count = r_lk_cnt;

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: self-checking bench for btb_predictor.
// Vector table plus directed LRU, stall, flush and reset sequences.
module tb_btb_predictor;

  localparam int SETS  = 16;
  localparam int WAYS  = 2;
  localparam int LANES = 2;
  localparam int CTR_W = 2;

  localparam logic [63:0] A   = 64'h1000;
  localparam logic [63:0] A40 = 64'h1040;
  localparam logic [63:0] A80 = 64'h1080;
  localparam logic [63:0] B   = 64'h2004;
  localparam logic [63:0] C   = 64'h3008;
  localparam logic [63:0] D0  = 64'h1008;
  localparam logic [63:0] D1  = 64'h1048;
  localparam logic [63:0] D2  = 64'h1088;
  localparam logic [63:0] E   = 64'h5000;
  localparam logic [63:0] FAR = 64'h0000_0100_0000_1000;
  localparam logic [63:0] Z   = 64'h0;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                stall;
  logic [63:0]         lookup_pc;
  logic                pred_hit;
  logic                pred_taken;
  logic [63:0]         pred_target;
  logic [LANES-1:0]    upd_valid;
  logic [LANES*64-1:0] upd_pc;
  logic [LANES*64-1:0] upd_target;
  logic [LANES-1:0]    upd_taken;
  logic                flush_req;
  logic                flush_busy;
  logic [31:0]         hit_count;
  logic [31:0]         lookup_count;

  always #5 clk = ~clk;

  btb_predictor #(
    .SETS (SETS),
    .WAYS (WAYS),
    .LANES(LANES),
    .CTR_W(CTR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .stall       (stall),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .hit_count   (hit_count),
    .lookup_count(lookup_count)
  );

  typedef struct {
    logic        hit;
    logic        tk;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    logic [63:0] lpc;
    logic [1:0]  uv;
    logic [1:0]  tk;
    logic [63:0] p0;
    logic [63:0] t0;
    logic [63:0] p1;
    logic [63:0] t1;
    logic        eh;
    logic        et;
    logic [63:0] eg;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic [63:0] lpc,
    input logic [1:0]  uv,
    input logic [1:0]  tk,
    input logic [63:0] p0,
    input logic [63:0] t0,
    input logic [63:0] p1,
    input logic [63:0] t1,
    input logic        eh,
    input logic        et,
    input logic [63:0] eg
  );
    vec_t v;
    v.lpc = lpc;
    v.uv  = uv;
    v.tk  = tk;
    v.p0  = p0;
    v.t0  = t0;
    v.p1  = p1;
    v.t1  = t1;
    v.eh  = eh;
    v.et  = et;
    v.eg  = eg;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr_upd();
    upd_valid  = '0;
    upd_taken  = '0;
    upd_pc     = '0;
    upd_target = '0;
  endtask

  task automatic set_upd(
    input int          l,
    input logic [63:0] pc,
    input logic [63:0] tg,
    input logic        tk
  );
    upd_valid[l]           = 1'b1;
    upd_pc[l*64 +: 64]     = pc;
    upd_target[l*64 +: 64] = tg;
    upd_taken[l]           = tk;
  endtask

  // One cycle: drive lookup, queue its expected result, compare
  // once the registered prediction appears after the edge.
  task automatic step(
    input string       nm,
    input logic [63:0] lpc,
    input logic        eh,
    input logic        et,
    input logic [63:0] eg
  );
    exp_t e;
    lookup_pc = lpc;
    sbq.push_back('{eh, et, eg});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got 0 want 1", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_hit"}, 64'(pred_hit), 64'(e.hit));
      chk({nm, "_tk"}, 64'(pred_taken), 64'(e.tk));
      chk({nm, "_tgt"}, pred_target, e.tgt);
    end
    clr_upd();
    flush_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    stall     = 1'b0;
    flush_req = 1'b0;
    lookup_pc = '0;
    clr_upd();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sbq.delete();
  endtask

  task automatic chk_cnt(
    input string nm,
    input int    lk,
    input int    hc
  );
    chk({nm, "_lookups"}, 64'(lookup_count), 64'(lk));
    chk({nm, "_hits"}, 64'(hit_count), 64'(hc));
  endtask

  initial begin
    int ml;
    int mh;
    int n;

    tv.push_back(mk(A, 2'b00, 2'b00, Z, Z, Z, Z, 1'b0, 1'b0, Z));
    tv.push_back(mk(A, 2'b01, 2'b01, A, 64'h2000, Z, Z,
                    1'b0, 1'b0, Z));
    tv.push_back(mk(A, 2'b00, 2'b00, Z, Z, Z, Z,
                    1'b1, 1'b1, 64'h2000));
    tv.push_back(mk(FAR, 2'b00, 2'b00, Z, Z, Z, Z,
                    1'b0, 1'b0, Z));
    tv.push_back(mk(A, 2'b01, 2'b01, A, 64'h2000, Z, Z,
                    1'b1, 1'b1, 64'h2000));
    tv.push_back(mk(A, 2'b01, 2'b01, A, 64'h2000, Z, Z,
                    1'b1, 1'b1, 64'h2000));
    tv.push_back(mk(A, 2'b01, 2'b00, A, 64'h2000, Z, Z,
                    1'b1, 1'b1, 64'h2000));
    tv.push_back(mk(A, 2'b01, 2'b00, A, 64'h2000, Z, Z,
                    1'b1, 1'b1, 64'h2000));
    tv.push_back(mk(A, 2'b00, 2'b00, Z, Z, Z, Z,
                    1'b1, 1'b0, 64'h2000));
    tv.push_back(mk(A, 2'b01, 2'b00, A, 64'h2000, Z, Z,
                    1'b1, 1'b0, 64'h2000));
    tv.push_back(mk(A, 2'b00, 2'b00, Z, Z, Z, Z,
                    1'b0, 1'b0, Z));
    tv.push_back(mk(B, 2'b01, 2'b01, B, 64'h5000, Z, Z,
                    1'b0, 1'b0, Z));
    tv.push_back(mk(B, 2'b01, 2'b00, B, 64'h5000, Z, Z,
                    1'b1, 1'b1, 64'h5000));
    tv.push_back(mk(B, 2'b01, 2'b01, B, 64'h6000, Z, Z,
                    1'b1, 1'b0, 64'h5000));
    tv.push_back(mk(B, 2'b00, 2'b00, Z, Z, Z, Z,
                    1'b1, 1'b1, 64'h6000));
    tv.push_back(mk(C, 2'b10, 2'b10, Z, Z, C, 64'h7000,
                    1'b0, 1'b0, Z));
    tv.push_back(mk(C, 2'b00, 2'b00, Z, Z, Z, Z,
                    1'b1, 1'b1, 64'h7000));

    do_reset();
    chk("rst_hit", 64'(pred_hit), 64'(1'b0));
    chk("rst_tk", 64'(pred_taken), 64'(1'b0));
    chk("rst_tgt", pred_target, Z);
    chk("rst_busy", 64'(flush_busy), 64'(1'b0));
    chk_cnt("rst", 0, 0);

    ml = 0;
    mh = 0;
    foreach (tv[i]) begin
      clr_upd();
      if (tv[i].uv[0])
        set_upd(0, tv[i].p0, tv[i].t0, tv[i].tk[0]);
      if (tv[i].uv[1])
        set_upd(1, tv[i].p1, tv[i].t1, tv[i].tk[1]);
      step($sformatf("vec%0d", i), tv[i].lpc,
           tv[i].eh, tv[i].et, tv[i].eg);
      ml++;
      if (tv[i].eh) mh++;
      chk_cnt($sformatf("vec%0d", i), ml, mh);
    end

    do_reset();
    set_upd(0, A, 64'h3000, 1'b1);
    set_upd(1, A, 64'h3000, 1'b1);
    step("dual_a", A, 1'b0, 1'b0, Z);
    step("dual_b", A, 1'b1, 1'b1, 64'h3000);
    set_upd(0, A, 64'h3000, 1'b0);
    step("dual_c", A, 1'b1, 1'b1, 64'h3000);
    set_upd(0, A, 64'h3000, 1'b0);
    step("dual_d", A, 1'b1, 1'b1, 64'h3000);
    step("dual_e", A, 1'b1, 1'b0, 64'h3000);
    set_upd(0, A, 64'h3000, 1'b0);
    step("dual_f", A, 1'b1, 1'b0, 64'h3000);
    step("dual_g", A, 1'b0, 1'b0, Z);

    do_reset();
    set_upd(0, A, 64'hA000, 1'b1);
    step("lru_a", Z, 1'b0, 1'b0, Z);
    set_upd(0, A40, 64'hB000, 1'b1);
    step("lru_b", Z, 1'b0, 1'b0, Z);
    step("lru_c", A40, 1'b1, 1'b1, 64'hB000);
    set_upd(0, A80, 64'hC000, 1'b1);
    step("lru_d", Z, 1'b0, 1'b0, Z);
    step("lru_e", A40, 1'b1, 1'b1, 64'hB000);
    step("lru_f", A80, 1'b1, 1'b1, 64'hC000);
    step("lru_g", A, 1'b0, 1'b0, Z);
    set_upd(0, D0, 64'hD000, 1'b1);
    step("lru2_a", Z, 1'b0, 1'b0, Z);
    set_upd(0, D1, 64'hD100, 1'b1);
    step("lru2_b", Z, 1'b0, 1'b0, Z);
    step("lru2_c", D0, 1'b1, 1'b1, 64'hD000);
    set_upd(0, D2, 64'hD200, 1'b1);
    step("lru2_d", Z, 1'b0, 1'b0, Z);
    step("lru2_e", D0, 1'b1, 1'b1, 64'hD000);
    step("lru2_f", D2, 1'b1, 1'b1, 64'hD200);
    step("lru2_g", D1, 1'b0, 1'b0, Z);

    do_reset();
    set_upd(0, A, 64'h2000, 1'b1);
    step("hold_a", Z, 1'b0, 1'b0, Z);
    step("hold_b", A, 1'b1, 1'b1, 64'h2000);
    stall = 1'b1;
    set_upd(0, E, 64'h9000, 1'b1);
    step("hold_c", E, 1'b1, 1'b1, 64'h2000);
    stall = 1'b0;
    step("hold_d", E, 1'b0, 1'b0, Z);
    enable = 1'b0;
    set_upd(0, E, 64'h9000, 1'b1);
    step("hold_e", A, 1'b0, 1'b0, Z);
    enable = 1'b1;
    step("hold_f", E, 1'b0, 1'b0, Z);
    chk_cnt("hold", 4, 1);

    do_reset();
    set_upd(0, A, 64'h2000, 1'b1);
    step("fl_a", A, 1'b0, 1'b0, Z);
    set_upd(0, B, 64'h5000, 1'b1);
    step("fl_b", B, 1'b0, 1'b0, Z);
    set_upd(0, C, 64'h7000, 1'b1);
    step("fl_c", C, 1'b0, 1'b0, Z);
    flush_req = 1'b1;
    step("fl_d", A, 1'b0, 1'b0, Z);
    n = 0;
    while (flush_busy === 1'b1 && n < 40) begin
      n++;
      set_upd(0, 64'h4000, 64'h8000, 1'b1);
      step("fl_walk", A, 1'b0, 1'b0, Z);
    end
    chk("fl_busy_cycles", 64'(n), 64'(16));
    chk_cnt("fl_walk", 4, 1);
    step("fl_e", A, 1'b0, 1'b0, Z);
    step("fl_f", B, 1'b0, 1'b0, Z);
    step("fl_g", C, 1'b0, 1'b0, Z);
    step("fl_h", 64'h4000, 1'b0, 1'b0, Z);

    do_reset();
    set_upd(0, A, 64'h2000, 1'b1);
    step("rw_a", Z, 1'b0, 1'b0, Z);
    flush_req = 1'b1;
    step("rw_b", A, 1'b0, 1'b0, Z);
    for (int k = 0; k < 4; k++)
      step("rw_walk", A, 1'b0, 1'b0, Z);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rw_busy", 64'(flush_busy), 64'(1'b0));
    chk("rw_hit", 64'(pred_hit), 64'(1'b0));
    chk_cnt("rw", 0, 0);
    step("rw_c", A, 1'b0, 1'b0, Z);
    flush_req = 1'b1;
    step("rw_d", A, 1'b0, 1'b0, Z);
    n = 0;
    while (flush_busy === 1'b1 && n < 40) begin
      enable = (n >= 4 && n < 7) ? 1'b0 : 1'b1;
      n++;
      step("rw_walk2", A, 1'b0, 1'b0, Z);
    end
    enable = 1'b1;
    chk("rw_busy_cycles", 64'(n), 64'(19));
    chk_cnt("rw_end", 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
